// File: rtl/mem_access_unit.sv
// mem_access_unit: turns CPU byte/half/word load/store requests into 32-bit word
// accesses on a RAM without byte enables. Sub-word stores are read-modify-write;
// misaligned or reserved-size requests are answered with an error and never touch RAM.
//
// Handshake: a request is accepted on a rising edge where req_valid & req_ready;
// req_ready is high only in IDLE, and request fields are latched on that edge.
// Completion is a single-cycle rsp_valid pulse (qualified by rsp_err) with no
// backpressure; the next request can be accepted one cycle after the pulse.
module mem_access_unit #(
   parameter int RD_LAT = 2
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_datain,
   input  logic [31:0] mem_dataout,
   output logic [2:0]  o_dbg_state
);

   localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
   // Loads capture the read word on the RD_LAT-th edge after the address goes out.
   // Sub-word stores capture one edge later; that edge is the merge slot in their
   // RD_LAT+3 turnaround (the RAM keeps driving the same word since mem_addr holds).
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_STORE = CNT_W'(RD_LAT);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_RESP  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_signed;
   logic [1:0]        r_lane;
   logic [15:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic              r_mem_we;
   logic [31:0]       r_mem_addr;
   logic [31:0]       r_mem_datain;

   logic              w_req_misaligned;
   logic [7:0]        w_lane_byte;
   logic [15:0]       w_lane_half;
   logic [31:0]       w_load_word;
   logic [31:0]       w_merged;

   // Alignment check on the incoming request; reserved size counts as misaligned.
   always_comb begin
      w_req_misaligned = 1'b0;
      case (req_size)
         2'b00:   w_req_misaligned = 1'b0;
         2'b01:   w_req_misaligned = req_addr[0];
         2'b10:   w_req_misaligned = |req_addr[1:0];
         default: w_req_misaligned = 1'b1;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               if (w_req_misaligned)                   w_next_state = ST_ERR;
               else if (req_we && req_size == 2'b10)   w_next_state = ST_WRITE;
               else                                    w_next_state = ST_READ;
            end
         end
         ST_READ: begin
            if (r_cnt == '0) w_next_state = r_we ? ST_WRITE : ST_RESP;
         end
         ST_WRITE: w_next_state = ST_RESP;
         ST_RESP:  w_next_state = ST_IDLE;
         ST_ERR:   w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Lane extraction (loads) and lane merge (sub-word stores) on the read word.
   always_comb begin
      w_lane_byte = mem_dataout[7:0];
      case (r_lane)
         2'd0: w_lane_byte = mem_dataout[7:0];
         2'd1: w_lane_byte = mem_dataout[15:8];
         2'd2: w_lane_byte = mem_dataout[23:16];
         2'd3: w_lane_byte = mem_dataout[31:24];
         default: w_lane_byte = mem_dataout[7:0];
      endcase
      w_lane_half = r_lane[1] ? mem_dataout[31:16] : mem_dataout[15:0];

      w_load_word = mem_dataout;
      case (r_size)
         2'b00:   w_load_word = {{24{r_signed & w_lane_byte[7]}}, w_lane_byte};
         2'b01:   w_load_word = {{16{r_signed & w_lane_half[15]}}, w_lane_half};
         default: w_load_word = mem_dataout;
      endcase

      w_merged = mem_dataout;
      if (r_size == 2'b00) begin
         case (r_lane)
            2'd0: w_merged[7:0]   = r_wdata[7:0];
            2'd1: w_merged[15:8]  = r_wdata[7:0];
            2'd2: w_merged[23:16] = r_wdata[7:0];
            2'd3: w_merged[31:24] = r_wdata[7:0];
            default: w_merged = mem_dataout;
         endcase
      end else if (r_size == 2'b01) begin
         if (r_lane[1]) w_merged[31:16] = r_wdata[15:0];
         else           w_merged[15:0]  = r_wdata[15:0];
      end
   end

   // Request latch, read counter, RAM port registers and response data.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_cnt        <= '0;
         r_we         <= 1'b0;
         r_size       <= 2'b00;
         r_signed     <= 1'b0;
         r_lane       <= 2'b00;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_datain <= '0;
      end else begin
         // Write enable is high exactly for the single cycle spent in WRITE.
         r_mem_we <= (w_next_state == ST_WRITE);
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_size   <= req_size;
                  r_signed <= req_signed;
                  r_lane   <= req_addr[1:0];
                  r_wdata  <= req_wdata[15:0];
                  if (w_req_misaligned) begin
                     r_rdata <= '0;
                  end else begin
                     r_mem_addr <= {req_addr[31:2], 2'b00};
                     r_cnt      <= req_we ? CNT_STORE : CNT_LOAD;
                     if (req_we && req_size == 2'b10) r_mem_datain <= req_wdata;
                  end
               end
            end
            ST_READ: begin
               if (r_cnt != '0)  r_cnt        <= r_cnt - CNT_W'(1);
               else if (r_we)    r_mem_datain <= w_merged;
               else              r_rdata      <= w_load_word;
            end
            ST_WRITE: r_rdata <= '0;
            default: ;
         endcase
      end
   end

   assign req_ready   = (r_state == ST_IDLE);
   assign rsp_valid   = (r_state == ST_RESP) || (r_state == ST_ERR);
   assign rsp_err     = (r_state == ST_ERR);
   assign rsp_rdata   = r_rdata;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_datain  = r_mem_datain;
   assign o_dbg_state = r_state;

endmodule
